ram_arbiter: RTL and testbench

//  Shares one single-port synchronous RAM (registered read, 1-cycle latency,
//  cs/we/addr/data_in/data_out) between two requesters: port 0 (6502 bus) and

---
 rtl/ram_arbiter.sv | 99 +++++++++
 tb/tb_ram_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-port req/ack arbiter in front of one single-port synchronous RAM.
// Each access runs IDLE -> ACCESS -> RESP; round-robin or fixed priority.
module ram_arbiter #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8,
   parameter int FIXED_PRIO = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  m0_req,
   input  logic                  m0_we,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   output logic                  m0_ack,
   output logic [DATA_WIDTH-1:0] m0_rdata,
   input  logic                  m1_req,
   input  logic                  m1_we,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   output logic                  m1_ack,
   output logic [DATA_WIDTH-1:0] m1_rdata,
   output logic                  ram_cs,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_rdata,
   output logic                  busy
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] RESP   = 2'd2;

   logic [1:0] state;
   logic       grant;
   logic       last_grant;
   logic       win;

   // Contention goes to the port that did not win last time.
   always_comb begin
      win = 1'b0;
      if (m0_req && m1_req)
         win = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
      else if (m1_req)
         win = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         grant      <= 1'b0;
         last_grant <= 1'b1;
         m0_ack     <= 1'b0;
         m1_ack     <= 1'b0;
         ram_cs     <= 1'b0;
         ram_we     <= 1'b0;
         ram_addr   <= '0;
         ram_wdata  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (m0_req || m1_req) begin
                  state     <= ACCESS;
                  grant     <= win;
                  ram_cs    <= 1'b1;
                  ram_we    <= win ? m1_we    : m0_we;
                  ram_addr  <= win ? m1_addr  : m0_addr;
                  ram_wdata <= win ? m1_wdata : m0_wdata;
               end
            end
            ACCESS: begin
               state  <= RESP;
               ram_cs <= 1'b0;
               ram_we <= 1'b0;
               m0_ack <= ~grant;
               m1_ack <= grant;
            end
            RESP: begin
               state      <= IDLE;
               m0_ack     <= 1'b0;
               m1_ack     <= 1'b0;
               last_grant <= grant;
            end
            default: begin
               state  <= IDLE;
               m0_ack <= 1'b0;
               m1_ack <= 1'b0;
               ram_cs <= 1'b0;
               ram_we <= 1'b0;
            end
         endcase
      end
   end

   assign busy     = (state != IDLE);
   assign m0_rdata = m0_ack ? ram_rdata : '0;
   assign m1_rdata = m1_ack ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: round-robin instance with a RAM model and scoreboard,
// plus a fixed-priority instance for the priority corner case.
module tb_ram_arbiter;

   localparam int AW = 16;
   localparam int DW = 8;

   typedef struct {
      bit            port;
      logic [DW-1:0] rdata;
   } exp_t;

   typedef struct {
      bit            p;
      bit            we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [DW-1:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          m0_req, m0_we, m0_ack;
   logic [AW-1:0] m0_addr;
   logic [DW-1:0] m0_wdata, m0_rdata;
   logic          m1_req, m1_we, m1_ack;
   logic [AW-1:0] m1_addr;
   logic [DW-1:0] m1_wdata, m1_rdata;
   logic          ram_cs, ram_we, busy;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata = '0;

   logic          f0_req, f0_we, f0_ack;
   logic [AW-1:0] f0_addr;
   logic [DW-1:0] f0_wdata, f0_rdata;
   logic          f1_req, f1_we, f1_ack;
   logic [AW-1:0] f1_addr;
   logic [DW-1:0] f1_wdata, f1_rdata;
   logic          f_cs, f_we, f_busy;
   logic [AW-1:0] f_addr;
   logic [DW-1:0] f_wdata;
   logic [DW-1:0] f_rdata = '0;

   ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(0)) u_rr (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
      .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
   );

   ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(1)) u_fp (
      .clk(clk), .rst_n(rst_n),
      .m0_req(f0_req), .m0_we(f0_we), .m0_addr(f0_addr),
      .m0_wdata(f0_wdata), .m0_ack(f0_ack), .m0_rdata(f0_rdata),
      .m1_req(f1_req), .m1_we(f1_we), .m1_addr(f1_addr),
      .m1_wdata(f1_wdata), .m1_ack(f1_ack), .m1_rdata(f1_rdata),
      .ram_cs(f_cs), .ram_we(f_we), .ram_addr(f_addr),
      .ram_wdata(f_wdata), .ram_rdata(f_rdata), .busy(f_busy)
   );

   // Registered-read RAM: a write returns the old contents.
   logic [DW-1:0] mem [logic [AW-1:0]];
   always @(posedge clk) begin
      if (ram_cs) begin
         ram_rdata <= mem.exists(ram_addr) ? mem[ram_addr] : '0;
         if (ram_we) mem[ram_addr] = ram_wdata;
      end
   end

   always @(posedge clk) begin
      if (f_cs)
         f_rdata <= f_we ? f_wdata : (f_addr[7:0] ^ f_addr[15:8]);
   end

   int   n_checks = 0;
   int   n_fail = 0;
   exp_t sb[$];
   exp_t e;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && (m0_ack || m1_ack)) begin
         chk("ack_overlap", {31'd0, m0_ack & m1_ack}, 0);
         chk("busy_resp", {31'd0, busy}, 1);
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected_ack: got ack%0d expected none",
                     m1_ack);
         end else begin
            e = sb.pop_front();
            chk("ack_port", {31'd0, m1_ack}, {31'd0, e.port});
            chk("rdata", m1_ack ? m1_rdata : m0_rdata, e.rdata);
            chk("other_rdata", m1_ack ? m0_rdata : m1_rdata, 0);
         end
      end
   end

   task automatic drive(input bit p, input bit req, input bit we,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (p) begin
         m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d;
      end else begin
         m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d;
      end
   endtask

   task automatic wait_ack(input bit p, output int lat);
      lat = -1;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         if (p ? m1_ack : m0_ack) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic access(input vec_t v);
      int lat;
      @(negedge clk);
      sb.push_back('{v.p, v.exp});
      drive(v.p, 1'b1, v.we, v.a, v.d);
      wait_ack(v.p, lat);
      chk("access_latency", lat, 2);
      drive(v.p, 1'b0, 1'b0, v.a, v.d);
   endtask

   vec_t vt[8];
   int   lat;
   int   acks;
   int   last;
   int   fa0;
   int   fa1;

   initial begin
      vt[0] = '{0, 1, 16'h0010, 8'hA5, 8'h00};
      vt[1] = '{0, 0, 16'h0010, 8'h00, 8'hA5};
      vt[2] = '{0, 1, 16'h0020, 8'h11, 8'h00};
      vt[3] = '{1, 1, 16'h0020, 8'h22, 8'h11};
      vt[4] = '{1, 0, 16'h0020, 8'h00, 8'h22};
      vt[5] = '{1, 0, 16'hFFFF, 8'h00, 8'h00};
      vt[6] = '{0, 1, 16'hFFFF, 8'h5A, 8'h00};
      vt[7] = '{1, 0, 16'hFFFF, 8'h00, 8'h5A};

      f0_req = 0; f0_we = 0; f0_addr = '0; f0_wdata = '0;
      f1_req = 0; f1_we = 0; f1_addr = '0; f1_wdata = '0;

      // Reset held with both ports requesting
      rst_n = 1'b0;
      drive(0, 1'b1, 1'b0, 16'h0100, 8'h00);
      drive(1, 1'b1, 1'b0, 16'h0200, 8'h00);
      repeat (3) @(negedge clk);
      chk("rst_cs", {31'd0, ram_cs}, 0);
      chk("rst_we", {31'd0, ram_we}, 0);
      chk("rst_addr", {16'd0, ram_addr}, 0);
      chk("rst_wdata", {24'd0, ram_wdata}, 0);
      chk("rst_ack0", {31'd0, m0_ack}, 0);
      chk("rst_ack1", {31'd0, m1_ack}, 0);
      chk("rst_rdata0", {24'd0, m0_rdata}, 0);
      chk("rst_rdata1", {24'd0, m1_rdata}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_fbusy", {31'd0, f_busy}, 0);
      rst_n = 1'b1;
      sb.push_back('{0, 8'h00});
      sb.push_back('{1, 8'h00});
      @(negedge clk);
      chk("rel_cs", {31'd0, ram_cs}, 1);
      chk("rel_addr", {16'd0, ram_addr}, 32'h0100);
      chk("rel_busy", {31'd0, busy}, 1);
      wait_ack(0, lat);
      chk("rel_p0_lat", lat, 1);
      drive(0, 1'b0, 1'b0, 16'h0100, 8'h00);
      wait_ack(1, lat);
      chk("rel_p1_lat", lat, 3);
      drive(1, 1'b0, 1'b0, 16'h0200, 8'h00);

      for (int i = 0; i < 8; i++) access(vt[i]);

      // Round-robin contention: both ports hold req high
      @(negedge clk);
      drive(0, 1'b1, 1'b0, 16'h0010, 8'h00);
      drive(1, 1'b1, 1'b0, 16'h0020, 8'h00);
      repeat (2) begin
         sb.push_back('{0, 8'hA5});
         sb.push_back('{1, 8'h22});
      end
      acks = 0;
      last = -1;
      for (int c = 0; c < 30 && acks < 4; c++) begin
         @(negedge clk);
         if (m0_ack || m1_ack) begin
            if (last >= 0) chk("rr_gap", c - last, 3);
            last = c;
            acks++;
         end
      end
      drive(0, 1'b0, 1'b0, 16'h0010, 8'h00);
      drive(1, 1'b0, 1'b0, 16'h0020, 8'h00);
      chk("rr_ack_count", acks, 4);

      // Reset during ACCESS abandons the transfer
      @(negedge clk);
      drive(0, 1'b1, 1'b0, 16'h0010, 8'h00);
      @(negedge clk);
      chk("mid_cs", {31'd0, ram_cs}, 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_cs", {31'd0, ram_cs}, 0);
      chk("mid_rst_busy", {31'd0, busy}, 0);
      chk("mid_rst_ack", {31'd0, m0_ack}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      sb.push_back('{0, 8'hA5});
      wait_ack(0, lat);
      chk("mid_reserve_lat", lat, 2);
      drive(0, 1'b0, 1'b0, 16'h0010, 8'h00);
      @(negedge clk);
      chk("sb_empty", sb.size(), 0);

      // Fixed priority: port 0 keeps re-requesting
      @(negedge clk);
      f0_req = 1'b1; f0_addr = 16'h0042;
      f1_req = 1'b1; f1_addr = 16'h0077;
      fa0 = 0;
      fa1 = 0;
      repeat (15) begin
         @(negedge clk);
         if (f0_ack) begin
            fa0++;
            chk("fp_rdata0", {24'd0, f0_rdata}, 32'h42);
            chk("fp_busy", {31'd0, f_busy}, 1);
         end
         if (f1_ack) fa1++;
      end
      chk("fp_p0_count", fa0, 5);
      chk("fp_p1_count", fa1, 0);
      f0_req = 1'b0;
      lat = -1;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         if (f1_ack) begin
            lat = n;
            chk("fp_rdata1", {24'd0, f1_rdata}, 32'h77);
            chk("fp_rdata0_idle", {24'd0, f0_rdata}, 0);
            break;
         end
      end
      chk("fp_p1_lat", lat, 2);
      f1_req = 1'b0;
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
